// File: rtl/instr_fetch_sequencer.sv
// ============================================================================
// Module      : instr_fetch_sequencer
// Description : Owns the program counter and runs a req/ack fetch against a
//               variable-latency instruction memory. Holds the fetched word
//               stable for the single-cycle control decoder and computes the
//               next PC (sequential or branch) when the datapath commits.
//               A misaligned PC parks the block in a sticky FAULT state.
// Ports       : CLK/Reset_L              clock, async active-low reset
//               StartPC                  boot address (sampled in BOOT)
//               ImemReq/Addr/Ack/Data    instruction memory handshake
//               Instruction/Opcode       held word and its [31:21] opcode
//               InstrValid               held word valid for execution
//               Commit/Branch/Uncondbranch/Zero/BranchOffset
//                                        next-PC controls from the datapath
//               PC/Fault/RetireCount     status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_sequencer #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 32
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic [ADDR_W-1:0]  StartPC,
    output logic               ImemReq,
    output logic [ADDR_W-1:0]  ImemAddr,
    input  logic               ImemAck,
    input  logic [INSTR_W-1:0] ImemData,
    output logic [INSTR_W-1:0] Instruction,
    output logic [10:0]        Opcode,
    output logic               InstrValid,
    input  logic               Commit,
    input  logic               Branch,
    input  logic               Uncondbranch,
    input  logic               Zero,
    input  logic [ADDR_W-1:0]  BranchOffset,
    output logic [ADDR_W-1:0]  PC,
    output logic               Fault,
    output logic [CNT_W-1:0]   RetireCount
);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              pc_misaligned;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] seq_target;
    logic [ADDR_W-1:0] pc_nxt;

    assign pc_misaligned = |PC[1:0];

    // Uncondbranch wins; Zero only matters for a conditional branch.
    assign branch_taken  = Uncondbranch | (Branch & Zero);
    // Word offset shifted left by two; the top two offset bits fall off.
    assign branch_target = PC + {BranchOffset[ADDR_W-3:0], 2'b00};
    assign seq_target    = PC + ADDR_W'(4);
    assign pc_nxt        = branch_taken ? branch_target : seq_target;

    // Combinational outputs: request decoded from state, address is the PC.
    assign ImemReq  = ((state == S_FETCH) && !pc_misaligned) || (state == S_WAIT);
    assign ImemAddr = PC;
    assign Opcode   = Instruction[31:21];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  state_nxt = S_FETCH;
            S_FETCH: begin
                if (pc_misaligned)  state_nxt = S_FAULT;
                else if (ImemAck)   state_nxt = S_HOLD;
                else                state_nxt = S_WAIT;
            end
            S_WAIT:  if (ImemAck) state_nxt = S_HOLD;
            S_HOLD:  if (Commit)  state_nxt = S_FETCH;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_BOOT;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) state <= S_BOOT;
        else          state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Registered datapath / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            PC          <= '0;
            Instruction <= '0;
            InstrValid  <= 1'b0;
            Fault       <= 1'b0;
            RetireCount <= '0;
        end else begin
            case (state)
                S_BOOT: PC <= StartPC;
                S_FETCH: begin
                    if (pc_misaligned) begin
                        Fault <= 1'b1;
                    end else if (ImemAck) begin
                        Instruction <= ImemData;
                        InstrValid  <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ImemAck) begin
                        Instruction <= ImemData;
                        InstrValid  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (Commit) begin
                        PC          <= pc_nxt;
                        RetireCount <= RetireCount + CNT_W'(1);
                        InstrValid  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_sequencer.sv
// ============================================================================
// Module      : tb_instr_fetch_sequencer
// Description : Self-checking bench for instr_fetch_sequencer. Directed boot,
//               branch, fault and reset scenarios followed by a randomized run
//               of fetch latencies and commit controls, checked against an
//               architectural PC/retire-count model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_sequencer;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 32;

    logic               CLK;
    logic               Reset_L;
    logic [ADDR_W-1:0]  StartPC;
    logic               ImemReq;
    logic [ADDR_W-1:0]  ImemAddr;
    logic               ImemAck;
    logic [INSTR_W-1:0] ImemData;
    logic [INSTR_W-1:0] Instruction;
    logic [10:0]        Opcode;
    logic               InstrValid;
    logic               Commit;
    logic               Branch;
    logic               Uncondbranch;
    logic               Zero;
    logic [ADDR_W-1:0]  BranchOffset;
    logic [ADDR_W-1:0]  PC;
    logic               Fault;
    logic [CNT_W-1:0]   RetireCount;

    instr_fetch_sequencer #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK         (CLK),
        .Reset_L     (Reset_L),
        .StartPC     (StartPC),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemAck     (ImemAck),
        .ImemData    (ImemData),
        .Instruction (Instruction),
        .Opcode      (Opcode),
        .InstrValid  (InstrValid),
        .Commit      (Commit),
        .Branch      (Branch),
        .Uncondbranch(Uncondbranch),
        .Zero        (Zero),
        .BranchOffset(BranchOffset),
        .PC          (PC),
        .Fault       (Fault),
        .RetireCount (RetireCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Architectural reference state
    logic [ADDR_W-1:0]  m_pc;
    logic [CNT_W-1:0]   m_cnt;
    logic [INSTR_W-1:0] m_instr;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reset with a given boot address; returns at the negedge of the FETCH cycle.
    task automatic do_reset(input logic [ADDR_W-1:0] start);
        @(negedge CLK);
        Reset_L = 1'b0; StartPC = start; ImemAck = 1'b0; Commit = 1'b0;
        Branch = 1'b0; Uncondbranch = 1'b0; Zero = 1'b0;
        @(negedge CLK);
        chk("rst_pc",    PC,          0);
        chk("rst_instr", Instruction, 0);
        chk("rst_valid", InstrValid,  0);
        chk("rst_req",   ImemReq,     0);
        chk("rst_fault", Fault,       0);
        chk("rst_cnt",   RetireCount, 0);
        Reset_L = 1'b1;
        @(negedge CLK);
        m_pc  = start;
        m_cnt = '0;
    endtask

    // Called at the negedge of a FETCH cycle; ack arrives after lat WAIT cycles.
    task automatic fetch(input int lat, input logic [INSTR_W-1:0] data);
        logic [ADDR_W-1:0] addr0;
        addr0 = ImemAddr;
        chk("fetch_req",   ImemReq,    1);
        chk("fetch_addr",  ImemAddr,   m_pc);
        chk("fetch_valid", InstrValid, 0);
        ImemAck  = (lat == 0);
        ImemData = (lat == 0) ? data : INSTR_W'($urandom);
        for (int i = 1; i <= lat; i++) begin
            @(negedge CLK);
            chk("wait_req",   ImemReq,    1);
            chk("wait_addr",  ImemAddr,   addr0);
            chk("wait_valid", InstrValid, 0);
            ImemAck  = (i == lat);
            ImemData = (i == lat) ? data : INSTR_W'($urandom);
        end
        @(negedge CLK);
        ImemAck  = 1'b0;
        ImemData = INSTR_W'($urandom);
        m_instr  = data;
        chk("hold_valid",  InstrValid,  1);
        chk("hold_instr",  Instruction, data);
        chk("hold_opcode", Opcode,      64'(data >> 21));
        chk("hold_req",    ImemReq,     0);
        chk("hold_pc",     PC,          m_pc);
    endtask

    // Called at the negedge of a HOLD cycle; stalls, then pulses Commit.
    task automatic commit(input logic br, input logic ub, input logic z,
                          input logic [ADDR_W-1:0] off, input int stall);
        for (int i = 0; i < stall; i++) begin
            ImemAck = 1'(($urandom % 2)); // stray acks must be ignored in HOLD
            @(negedge CLK);
            chk("stall_instr", Instruction, m_instr);
            chk("stall_valid", InstrValid,  1);
        end
        ImemAck = 1'b0;
        Branch = br; Uncondbranch = ub; Zero = z; BranchOffset = off; Commit = 1'b1;
        @(negedge CLK);
        Commit = 1'b0; Branch = 1'b0; Uncondbranch = 1'b0; Zero = 1'b0;
        if (ub || (br && z)) m_pc = m_pc + off * 4;
        else                 m_pc = m_pc + 4;
        m_cnt = m_cnt + 1;
        chk("commit_pc",    PC,          m_pc);
        chk("commit_cnt",   RetireCount, 64'(m_cnt));
        chk("commit_valid", InstrValid,  0);
    endtask

    initial begin
        Reset_L = 1'b0; StartPC = '0; ImemAck = 1'b0; ImemData = '0;
        Commit = 1'b0; Branch = 1'b0; Uncondbranch = 1'b0; Zero = 1'b0;
        BranchOffset = '0;
        m_pc = '0; m_cnt = '0; m_instr = '0;

        // Boot with zero-wait LDUR fetch
        do_reset(64'h100);
        fetch(0, 32'hF840_0000);
        chk("ldur_opcode", Opcode, 11'b11111000010);

        // Three sequential commits
        commit(1'b0, 1'b0, 1'b0, 64'h0, 0);
        chk("seq_pc1", PC, 64'h104);
        fetch(0, 32'h8B02_0020);
        commit(1'b0, 1'b0, 1'b1, 64'h55, 1);
        fetch(1, 32'hCB02_0020);
        commit(1'b0, 1'b0, 1'b0, 64'h0, 0);
        chk("seq_cnt3", RetireCount, 3);
        chk("seq_pc3",  PC, 64'h10C);

        // Three wait states
        fetch(3, 32'hB400_0040);
        commit(1'b0, 1'b0, 1'b0, 64'h0, 2);

        // CBZ taken from 0x200
        do_reset(64'h200);
        fetch(0, 32'hB4FF_FFC0);
        commit(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        chk("cbz_taken", PC, 64'h1F8);

        // CBZ not taken
        do_reset(64'h200);
        fetch(1, 32'hB4FF_FFC0);
        commit(1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        chk("cbz_not_taken", PC, 64'h204);

        // Unconditional B, Zero low
        do_reset(64'h200);
        fetch(2, 32'h1400_0010);
        commit(1'b0, 1'b1, 1'b0, 64'h10, 0);
        chk("b_taken", PC, 64'h240);

        // Wraparound at top of address space and offset top-bit discard
        do_reset(64'hFFFF_FFFF_FFFF_FFFC);
        fetch(0, 32'hD503_201F);
        commit(1'b0, 1'b0, 1'b0, 64'h0, 0);
        chk("wrap_pc", PC, 64'h0);
        fetch(0, 32'h1400_0001);
        commit(1'b0, 1'b1, 1'b0, 64'hC000_0000_0000_0001, 0);
        chk("off_discard_pc", PC, 64'h4);

        // Misaligned boot address -> sticky fault
        do_reset(64'h102);
        chk("fault_no_req", ImemReq, 0);
        ImemAck = 1'b1;
        @(negedge CLK);
        chk("fault_set",   Fault,      1);
        chk("fault_req",   ImemReq,    0);
        chk("fault_valid", InstrValid, 0);
        chk("fault_pc",    PC,         64'h102);
        Commit = 1'b1; Uncondbranch = 1'b1; BranchOffset = 64'h40;
        @(negedge CLK);
        Commit = 1'b0; Uncondbranch = 1'b0; ImemAck = 1'b0;
        @(negedge CLK);
        chk("fault_sticky",     Fault,       1);
        chk("fault_commit_pc",  PC,          64'h102);
        chk("fault_commit_cnt", RetireCount, 0);
        chk("fault_req2",       ImemReq,     0);
        #2 Reset_L = 1'b0;
        #1 chk("fault_async_clr", Fault, 0);

        // Reset in the middle of a WAIT
        do_reset(64'h300);
        ImemAck = 1'b0;
        @(negedge CLK);
        chk("midwait_req", ImemReq, 1);
        #2 Reset_L = 1'b0;
        #1 chk("midwait_req_drop", ImemReq, 0);
        chk("midwait_pc", PC, 0);
        ImemAck = 1'b1; ImemData = 32'hDEAD_BEEF;
        @(negedge CLK);
        Reset_L = 1'b1;                       // BOOT cycle, ack still high
        @(negedge CLK);
        chk("refetch_addr",  ImemAddr,   64'h300);
        chk("refetch_valid", InstrValid, 0);
        chk("refetch_instr", Instruction, 0);
        m_pc = 64'h300; m_cnt = '0;
        fetch(1, 32'hF840_0000);

        // Randomized run against the architectural model
        do_reset({32'h0, $urandom} & 64'h0000_0000_FFFF_FFFC);
        for (int n = 0; n < 40; n++) begin
            logic [ADDR_W-1:0] off;
            off = ADDR_W'(signed'($urandom_range(0, 127)) - 64);
            fetch(int'($urandom_range(0, 4)), INSTR_W'($urandom));
            commit(1'($urandom), 1'(($urandom % 4) == 0), 1'($urandom), off,
                   int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Upstream neighbour of the single-cycle control decoder. Owns the PC and runs a req/ack fetch from instruction memory, which may have variable latency.
- Holds the fetched word stable and presents Opcode[10:0] to the control decoder.
- Computes the next PC from the Branch, Uncondbranch and Zero results when the datapath pulses Commit.

Parameters:
- ADDR_W, 64, PC / instruction-address width
- INSTR_W, 32, instruction width (Opcode is always bits [31:21])
- CNT_W, 32, width of the retired-instruction counter

Ports:
- CLK  in  1  single clock, rising edge
- Reset_L  in  1  asynchronous, active-low reset
- StartPC  in  ADDR_W  boot address, sampled in BOOT
- ImemReq  out  1  fetch request to instruction memory
- ImemAddr  out  ADDR_W  fetch address, equals PC
- ImemAck  in  1  memory has returned data this cycle
- ImemData  in  INSTR_W  instruction word, valid when ImemAck=1
- Instruction  out  INSTR_W  held instruction word
- Opcode  out  11  Instruction[31:21], feeds the control decoder
- InstrValid  out  1  Instruction/Opcode are valid for execution
- Commit  in  1  datapath has finished the held instruction (single-cycle pulse)
- Branch  in  1  control Branch for the held instruction
- Uncondbranch  in  1  control Uncondbranch for the held instruction
- Zero  in  1  ALU zero flag for the held instruction
- BranchOffset  in  ADDR_W  sign-extended word offset, not yet shifted
- PC  out  ADDR_W  current PC
- Fault  out  1  sticky misaligned-PC fault
- RetireCount  out  CNT_W  number of committed instructions

Behaviour:
- Reset (Reset_L=0, asynchronous): state=BOOT, PC=0, Instruction=0, InstrValid=0, ImemReq=0, Fault=0, RetireCount=0.
- States: BOOT, FETCH, WAIT, HOLD, FAULT.
- BOOT: one cycle after reset release. PC<=StartPC; next state FETCH.
- FETCH:
  - If PC[1:0]!=0: go to FAULT without requesting.
  - Else ImemReq=1, ImemAddr=PC.
  - If ImemAck=1 in the same cycle: Instruction<=ImemData, go to HOLD (zero-wait fetch, InstrValid high the next cycle).
  - Else go to WAIT.
- WAIT: ImemReq stays 1 with ImemAddr stable. On ImemAck: capture ImemData, go to HOLD. No timeout; ImemAck outside FETCH/WAIT is ignored.
- HOLD:
  - InstrValid=1, ImemReq=0. Instruction and Opcode stay stable until Commit.
  - On Commit:
    - If Uncondbranch=1, or Branch=1 and Zero=1: PC<=PC+(BranchOffset<<2). Arithmetic is modulo 2^ADDR_W; the shift discards the top 2 bits.
    - Otherwise PC<=PC+4, wrapping at 2^ADDR_W.
    - RetireCount<=RetireCount+1, wrapping at 2^CNT_W.
    - InstrValid<=0; go to FETCH.
  - Commit while not in HOLD is ignored: no PC change, no count.
  - Uncondbranch has priority; Zero is ignored when Branch=0.
- FAULT: Fault=1, ImemReq=0, InstrValid=0. Remains here until reset. PC holds the offending address.
- Outputs are registered except ImemReq, ImemAddr and Opcode.
  - ImemReq is decoded from state (FETCH with aligned PC, or WAIT).
  - ImemAddr = PC.
  - Opcode = Instruction[31:21].
- Fetch latency: 1 cycle from FETCH to HOLD with an immediate ack, otherwise N+1 cycles for ack after N WAIT cycles.
- Reset mid-fetch or mid-HOLD aborts immediately. A late ImemAck after reset has no effect because the state is BOOT.

Test Plan:
- Boot: StartPC=0x100, ImemAck tied high, ImemData=0xF8400000 (LDUR) -> ImemAddr=0x100 in FETCH; next cycle InstrValid=1, Opcode=11'b11111000010.
- Sequential: Commit with Branch=0, Uncondbranch=0 -> PC=0x104; after 3 commits RetireCount=3 and PC=0x10C.
- Wait states: ack delayed 3 cycles -> ImemReq=1 and ImemAddr stable for 4 cycles, InstrValid=0 throughout, then valid.
- Branches, all from PC=0x200:
  - CBZ taken: Branch=1, Zero=1, BranchOffset=-2 -> PC=0x1F8.
  - CBZ not taken: Zero=0 -> PC=0x204.
  - B: Uncondbranch=1, Zero=0, BranchOffset=0x10 -> PC=0x240.
- Fault: StartPC=0x102 -> ImemReq never asserts, Fault=1 and sticky, Commit ignored; Reset_L low clears Fault=0.
- Reset mid-WAIT: Reset_L pulsed while ImemReq=1 -> ImemReq=0 immediately, later ImemAck ignored, refetch from StartPC.
